// File: rtl/vcache_hash_function.sv
// vcache_hash_function: registered split of a block address into vcache bank (i mod banks_p) and index (i / banks_p)
module vcache_hash_function #(
    parameter int banks_p = 8,
    parameter int width_p = 10,
    parameter int vcache_sets_p = 64,
    localparam int bank_width_lp = (banks_p == 1) ? 1 : $clog2(banks_p),
    localparam int index_width_lp = $clog2(((2 ** width_p) + banks_p - 1) / banks_p)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      v_i,
    input  logic [width_p-1:0]        i,
    output logic                      v_o,
    output logic [bank_width_lp-1:0]  bank_o,
    output logic [index_width_lp-1:0] index_o
);
    localparam bit pow2_lp = (banks_p >= 2) && ((banks_p & (banks_p - 1)) == 0);
    localparam int third_lp = banks_p / 3;
    localparam bit tri_lp = (banks_p >= 3) && (banks_p % 3 == 0) && ((third_lp & (third_lp - 1)) == 0);
    localparam int k_lp = (third_lp <= 1) ? 0 : $clog2(third_lp);

    if (!pow2_lp && !tri_lp) begin : g_bad_banks
        $error("vcache_hash_function: banks_p=%0d is neither 2^k (k>=1) nor 3*2^k", banks_p);
    end
    if ((2 ** width_p) < banks_p) begin : g_bad_width
        $error("vcache_hash_function: 2^width_p (width_p=%0d) is smaller than banks_p=%0d", width_p, banks_p);
    end
    if ((vcache_sets_p < 1) || ((vcache_sets_p & (vcache_sets_p - 1)) != 0)) begin : g_bad_sets
        $error("vcache_hash_function: vcache_sets_p=%0d is not a power of two", vcache_sets_p);
    end

    logic [bank_width_lp-1:0]  bank_c;
    logic [index_width_lp-1:0] index_c;

    if (pow2_lp) begin : g_pow2
        assign bank_c  = i[bank_width_lp-1:0];
        assign index_c = index_width_lp'(i[width_p-1:bank_width_lp]);
    end else if (tri_lp) begin : g_tri
        // Low k bits pass straight into the bank; only the upper part needs a divide by 3.
        logic [width_p-k_lp-1:0] hi;
        logic [1:0]              r3;
        assign hi      = i[width_p-1:k_lp];
        assign r3      = 2'(hi % 3);
        assign index_c = index_width_lp'(hi / 3);
        if (k_lp == 0) begin : g_k0
            assign bank_c = r3;
        end else begin : g_k
            assign bank_c = {r3, i[k_lp-1:0]};
        end
    end else begin : g_none
        assign bank_c  = '0;
        assign index_c = '0;
    end

    // Capture the hash only on valid inputs so idle (possibly X) addresses never reach the outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            v_o     <= 1'b0;
            bank_o  <= '0;
            index_o <= '0;
        end else begin
            v_o <= v_i;
            if (v_i) begin
                bank_o  <= bank_c;
                index_o <= index_c;
            end
        end
    end
endmodule

// File: tb/tb_vcache_hash_function.sv
// tb_vcache_hash_function: scoreboard bench for four bank configurations driven in lockstep
module tb_vcache_hash_function;
    logic       clk = 1'b0;
    logic       reset_i = 1'b0;
    logic       v_i = 1'b0;
    logic [9:0] addr = '0;

    logic       v8, v6, v12, v3;
    logic [2:0] b8, b6;
    logic [3:0] b12;
    logic [1:0] b3;
    logic [6:0] x8, x3;
    logic [7:0] x6;
    logic [4:0] x12;

    always #5 clk = ~clk;

    vcache_hash_function #(.banks_p(8), .width_p(10), .vcache_sets_p(64)) u_b8 (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .i(addr), .v_o(v8), .bank_o(b8), .index_o(x8));
    vcache_hash_function #(.banks_p(6), .width_p(10), .vcache_sets_p(64)) u_b6 (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .i(addr), .v_o(v6), .bank_o(b6), .index_o(x6));
    vcache_hash_function #(.banks_p(12), .width_p(8), .vcache_sets_p(32)) u_b12 (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .i(addr[7:0]), .v_o(v12), .bank_o(b12), .index_o(x12));
    vcache_hash_function #(.banks_p(3), .width_p(8), .vcache_sets_p(16)) u_b3 (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .i(addr[7:0]), .v_o(v3), .bank_o(b3), .index_o(x3));

    typedef struct {
        int b8, x8, b6, x6, b12, x12, b3, x3;
    } exp_t;

    exp_t q[$];
    exp_t last = '{default: 0};
    int   n_cmp = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    logic v_s, r_s;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(logic [9:0] a);
        exp_t e;
        int   w10 = int'(a);
        int   w8  = int'(a[7:0]);
        e.b8  = w10 % 8;
        e.x8  = w10 / 8;
        e.b6  = w10 % 6;
        e.x6  = w10 / 6;
        e.b12 = w8 % 12;
        e.x12 = w8 / 12;
        e.b3  = w8 % 3;
        e.x3  = w8 / 3;
        return e;
    endfunction

    task automatic drive(logic v, logic [9:0] a);
        @(negedge clk);
        v_i  = v;
        addr = a;
        if (v) q.push_back(model(a));
    endtask

    task automatic check_zero(string tag);
        check({tag, "_v8"}, 32'(v8), 0);
        check({tag, "_b8"}, 32'(b8), 0);
        check({tag, "_x8"}, 32'(x8), 0);
        check({tag, "_v6"}, 32'(v6), 0);
        check({tag, "_b6"}, 32'(b6), 0);
        check({tag, "_x6"}, 32'(x6), 0);
        check({tag, "_v12"}, 32'(v12), 0);
        check({tag, "_b12"}, 32'(b12), 0);
        check({tag, "_x12"}, 32'(x12), 0);
        check({tag, "_v3"}, 32'(v3), 0);
        check({tag, "_b3"}, 32'(b3), 0);
        check({tag, "_x3"}, 32'(x3), 0);
    endtask

    // Each edge: v_o must echo the v_i seen at that edge; data must match the newest popped result or hold.
    always @(posedge clk) begin
        v_s = v_i;
        r_s = reset_i;
        #1;
        if (mon_en && !r_s) begin
            check("v8", 32'(v8), 32'(v_s));
            check("v6", 32'(v6), 32'(v_s));
            check("v12", 32'(v12), 32'(v_s));
            check("v3", 32'(v3), 32'(v_s));
            if (v_s) begin
                check("sb_nonempty", 32'(q.size() != 0), 1);
                if (q.size() != 0) last = q.pop_front();
            end
            check("b8", 32'(b8), last.b8);
            check("x8", 32'(x8), last.x8);
            check("b6", 32'(b6), last.b6);
            check("x6", 32'(x6), last.x6);
            check("b12", 32'(b12), last.b12);
            check("x12", 32'(x12), last.x12);
            check("b3", 32'(b3), last.b3);
            check("x3", 32'(x3), last.x3);
        end
    end

    initial begin
        #1 reset_i = 1'b1;
        #1 check_zero("rst");
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        mon_en  = 1'b1;

        drive(1'b1, 10'd725);
        @(posedge clk);
        #2;
        check("d725_b8", 32'(b8), 5);
        check("d725_x8", 32'(x8), 90);
        check("d725_b6", 32'(b6), 5);
        check("d725_x6", 32'(x6), 120);

        drive(1'b1, 10'd1023);
        @(posedge clk);
        #2;
        check("d1023_b8", 32'(b8), 7);
        check("d1023_x8", 32'(x8), 127);
        check("d1023_b6", 32'(b6), 3);
        check("d1023_x6", 32'(x6), 170);
        check("d255_b12", 32'(b12), 3);
        check("d255_x12", 32'(x12), 21);
        check("d255_b3", 32'(b3), 0);
        check("d255_x3", 32'(x3), 85);

        drive(1'b1, 10'd0);
        @(posedge clk);
        #2;
        check("d0_b6", 32'(b6), 0);
        check("d0_x6", 32'(x6), 0);

        drive(1'b1, 10'h155);
        repeat (3) drive(1'b0, 'x);

        for (int a = 0; a < 256; a++) drive(1'b1, {2'($urandom_range(0, 3)), 8'(a)});
        drive(1'b0, '0);

        repeat (16) drive(1'b1, 10'($urandom));
        drive(1'b0, 'x);
        drive(1'b0, '0);

        drive(1'b1, 10'd725);
        drive(1'b1, 10'd300);
        @(posedge clk);
        #3;
        v_i     = 1'b0;
        reset_i = 1'b1;
        #1 check_zero("mid");
        q.delete();
        last = '{default: 0};
        @(negedge clk);
        reset_i = 1'b0;

        drive(1'b1, 10'd725);
        @(posedge clk);
        #2;
        check("post_b6", 32'(b6), 5);
        check("post_x6", 32'(x6), 120);
        drive(1'b0, '0);
        @(negedge clk);
        check("sb_drained", 32'(q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
